hidden_layer_seq: RTL and testbench
===================================

# hidden_layer_seq

Parametrised, time-multiplexed fully-connected hidden layer: N_IN signed fixed-point inputs, N_OUT neurons, one shared multiply-accumulate unit, per-neuron bias, selectable ReLU or linear saturating activation. Weights and biases live in an internal register file loaded over a simple write port. It is the next generation of the combinational hidden layer in the drowsiness-detector datapath: it trades latency for a single multiplier and adds start/done handshaking.

## Interface
- N_IN, 10, inputs per neuron
- N_OUT, 5, neurons
- DW, 10, data/weight width, signed two's complement
- FRAC, 4, fractional bits of all values (Q(DW-FRAC).FRAC)
- Clock  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- start  in  1  sample in_val/act_mode and begin; honoured only when busy=0
- act_mode  in  1  0 = ReLU, 1 = linear; sampled with start
- in_val  in  N_IN×DW  packed input vector, element k at [k*DW +: DW]
- WE  in  1  weight write enable
- w_addr  in  clog2(N_OUT*(N_IN+1))  address j*(N_IN+1)+k; k=N_IN selects bias of neuron j
- w_data  in  DW  weight/bias value
- out_val  out  N_OUT×DW  packed results, neuron j at [j*DW +: DW]
- done  out  1  one-cycle pulse, out_val freshly updated
- busy  out  1  high from the cycle after start until done

## Operation
- States: IDLE, MAC, FIN, DONE.
- IDLE: start=1 latches in_val and act_mode, clears accumulator, j=0, k=0 → MAC.
- MAC: acc += in[k]*w[j][k] (full 2·DW product); k==N_IN-1 → FIN, else k++.
- FIN: r = (acc + (bias[j] <<< FRAC)) >>> FRAC; ReLU: r<0 → 0; both modes saturate to [−2^(DW−1), 2^(DW−1)−1]. Result goes to shadow slot j; clear acc, k=0; j==N_OUT-1 → DONE, else j++ → MAC.
- DONE: copy all shadow slots to out_val at once, pulse done → IDLE.
- Accumulator width ACC_W = 2·DW + clog2(N_IN+1); no internal overflow.
- out_val holds its value between completions; it never shows partial results.
- start while busy: ignored. WE while busy: ignored (the weight file is stable for the whole pass). WE and start in the same idle cycle: both take effect; that pass uses the old weight at the written address.
- Reset (asynchronous, any state): state IDLE, out_val=0, shadow=0, all weights/biases=0, done=0, busy=0, accumulator=0. A pass in flight is discarded and done is not produced.

## Timing
- start sampled at edge t0 → busy=1 from t0 until done.
- MAC cycles N_IN per neuron, plus 1 FIN cycle; done=1 in the cycle after edge t0+N_OUT·(N_IN+1)+1. With defaults, done rises 56 cycles after t0.
- out_val changes only on the edge that raises done.
- busy falls on the same edge that lowers done. A new start is accepted in the following cycle.
- Weight write takes effect at the next edge. Readback is internal only.

## Structure
- Package hidden_layer_pkg: state enum (IDLE, MAC, FIN, DONE), ACT_RELU/ACT_LINEAR constants, function sat_dw(acc) for saturation and ReLU, function acc_width(DW, N_IN).
- Sub-module hl_mac_unit: signed multiply-accumulate with synchronous clear and async active-low reset, parametrised by DW and ACC_W.
- Top holds the FSM, counters j/k, the weight register file, the input latch, and the shadow and output registers.

## Test plan
- Reset: Rst low 3 cycles → out_val=0, done=0, busy=0; start with no weights loaded → all out_val=0, done at t0+56.
- Identity pass: all weights 16 (1.0), biases 0, all in_val 16, ReLU → every out_val=160 (10.0); done exactly 56 cycles after start.
- Saturation: weights 48 (3.0), inputs 64 (4.0) → raw 1920 → every out_val=511. Weights −48 in linear mode → −512 (10'h200).
- Activation: weights −16, inputs 16, bias 0 → ReLU gives 0; linear gives −160 (10'h360). Bias only: weights 0, bias[2]=40 → out_val[2]=40, others 0.
- Protocol: second start and WE to address 0 during busy → both ignored; result unchanged, weight 0 unchanged on the next pass; a single done pulse.
- Mid-pass reset: Rst low at cycle 20 of a pass → busy=0 immediately, no done, out_val=0. A later pass with reloaded weights gives the correct results.

Source files
------------

// File: rtl/hidden_layer_pkg.sv
// Shared types, constants and arithmetic helpers for the time-multiplexed hidden layer.
package hidden_layer_pkg;

  typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_e;

  localparam logic ACT_RELU   = 1'b0;
  localparam logic ACT_LINEAR = 1'b1;
  localparam int   WIDE_W     = 64;

  function automatic int acc_width(input int dw, input int n_in);
    return 2 * dw + $clog2(n_in + 1);
  endfunction

  // Clamp a wide signed value into the dw-bit signed range; ReLU floors negatives at zero first.
  function automatic logic signed [WIDE_W-1:0] sat_dw(input logic signed [WIDE_W-1:0] v,
                                                      input int dw, input logic relu);
    logic signed [WIDE_W-1:0] hi, lo, r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    r  = v;
    if (relu && (r < 64'sd0)) r = 64'sd0;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/hidden_layer_seq_mac.sv
// Signed multiply-accumulate: full-width product added into a wide accumulator, clear wins over enable.
module hl_mac_unit #(
  parameter int DW    = 10,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_d, acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/hidden_layer_seq.sv
// Time-multiplexed fully-connected layer: one MAC walks every (neuron, input) pair, then publishes all results at once.
module hidden_layer_seq
  import hidden_layer_pkg::*;
#(
  parameter int N_IN  = 10,
  parameter int N_OUT = 5,
  parameter int DW    = 10,
  parameter int FRAC  = 4,
  localparam int NW   = N_OUT * (N_IN + 1),
  localparam int AW   = $clog2(NW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                act_mode,
  input  logic [N_IN*DW-1:0]  in_val,
  input  logic                we,
  input  logic [AW-1:0]       w_addr,
  input  logic [DW-1:0]       w_data,
  output logic [N_OUT*DW-1:0] out_val,
  output logic                done,
  output logic                busy,
  output state_e              dbg_state
);

  localparam int ACC_W = acc_width(DW, N_IN);
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;

  // Handshake: start is taken only in a cycle where busy=0; busy then stays high through the
  // single-cycle done pulse, and out_val is valid (and stable) from that pulse onward.
  state_e               state_d, state_q;
  logic [JW-1:0]        j_d, j_q;
  logic [KW-1:0]        k_d, k_q;
  logic [N_IN*DW-1:0]   in_d, in_q;
  logic                 relu_d, relu_q;
  logic [N_OUT*DW-1:0]  shadow_d, shadow_q, out_d, out_q;
  logic                 done_d, done_q, busy_d, busy_q;
  logic [DW-1:0]        w_d [NW];
  logic [DW-1:0]        w_q [NW];
  logic                 pend_d, pend_q;
  logic [AW-1:0]        pend_addr_d, pend_addr_q;
  logic [DW-1:0]        pend_data_d, pend_data_q;

  logic                     mac_clr, mac_en;
  logic signed [DW-1:0]     mac_a, mac_b;
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            rd_addr, bias_addr;
  logic signed [WIDE_W-1:0] acc_ext, bias_ext, fin_sum;

  hl_mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .rst_n(rst_n), .clr(mac_clr), .en(mac_en),
    .a(mac_a), .b(mac_b), .acc(acc)
  );

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    k_d         = k_q;
    in_d        = in_q;
    relu_d      = relu_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    w_d         = w_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;

    rd_addr   = AW'(int'(j_q) * (N_IN + 1) + int'(k_q));
    bias_addr = AW'(int'(j_q) * (N_IN + 1) + N_IN);
    mac_a     = in_q[int'(k_q)*DW +: DW];
    mac_b     = w_q[rd_addr];
    acc_ext   = {{(WIDE_W-ACC_W){acc[ACC_W-1]}}, acc};
    bias_ext  = {{(WIDE_W-DW){w_q[bias_addr][DW-1]}}, w_q[bias_addr]};
    fin_sum   = acc_ext + (bias_ext <<< FRAC);

    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          in_d    = in_val;
          relu_d  = (act_mode == ACT_RELU);
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (int'(k_q) == N_IN - 1) state_d = FIN;
        else                       k_d = k_q + 1'b1;
      end
      FIN: begin
        shadow_d[int'(j_q)*DW +: DW] = DW'(sat_dw(fin_sum >>> FRAC, DW, relu_q));
        mac_clr = 1'b1;
        k_d     = '0;
        if (int'(j_q) == N_OUT - 1) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = MAC;
        end
      end
      DONE: begin
        out_d   = shadow_q;
        done_d  = 1'b1;
        state_d = IDLE;
        // A write that arrived with start is held back so the pass saw the old weight.
        if (pend_q) begin
          w_d[pend_addr_q] = pend_data_q;
          pend_d           = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (we && !busy_q && (int'(w_addr) < NW)) begin
      if (start) begin
        pend_d      = 1'b1;
        pend_addr_d = w_addr;
        pend_data_d = w_data;
      end else begin
        w_d[w_addr] = w_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      j_q         <= '0;
      k_q         <= '0;
      in_q        <= '0;
      relu_q      <= 1'b0;
      shadow_q    <= '0;
      out_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      k_q         <= k_d;
      in_q        <= in_d;
      relu_q      <= relu_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      for (int i = 0; i < NW; i++) w_q[i] <= w_d[i];
    end
  end

  assign out_val   = out_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Randomised bench for hidden_layer_seq against an arithmetic reference model of the layer.
module tb_hidden_layer_seq;
  import hidden_layer_pkg::*;

  localparam int N_IN = 10, N_OUT = 5, DW = 10, FRAC = 4;
  localparam int NW = N_OUT * (N_IN + 1);
  localparam int AW = $clog2(NW);
  localparam int IW = N_IN * DW, OW = N_OUT * DW;
  localparam int LAT = N_OUT * (N_IN + 1) + 1;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, act_mode = 1'b0, we = 1'b0;
  logic [IW-1:0] in_val = '0;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic [OW-1:0] out_val;
  logic          done, busy;
  state_e        dbg_state;

  int            wm[NW];
  int            n_vec = 0, n_err = 0;
  logic [OW-1:0] exp_q[$];

  hidden_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .act_mode(act_mode), .in_val(in_val),
    .we(we), .w_addr(w_addr), .w_data(w_data), .out_val(out_val), .done(done),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: dot product in plain integers, bias scaled to the product's fraction, floor shift, clamp.
  function automatic logic [OW-1:0] model(input logic [IW-1:0] iv, input logic mode);
    logic [OW-1:0]      o;
    logic [DW-1:0]      x;
    longint             s;
    logic signed [63:0] r;
    o = '0;
    for (int j = 0; j < N_OUT; j++) begin
      s = 0;
      for (int k = 0; k < N_IN; k++) begin
        x = iv[k*DW +: DW];
        s += longint'($signed(x)) * longint'(wm[j*(N_IN+1)+k]);
      end
      s += longint'(wm[j*(N_IN+1)+N_IN]) * (longint'(1) << FRAC);
      r = s >>> FRAC;
      if (mode == ACT_RELU && r < 0) r = 0;
      if (r > (2**(DW-1) - 1)) r = 2**(DW-1) - 1;
      if (r < -(2**(DW-1))) r = -(2**(DW-1));
      o[j*DW +: DW] = r[DW-1:0];
    end
    return o;
  endfunction

  function automatic logic [IW-1:0] rand_vec(input int lo, input int hi);
    logic [IW-1:0] v;
    int            e;
    for (int k = 0; k < N_IN; k++) begin
      e = int'($urandom_range(0, hi - lo)) + lo;
      v[k*DW +: DW] = DW'(e);
    end
    return v;
  endfunction

  function automatic logic [IW-1:0] const_vec(input int e);
    logic [IW-1:0] v;
    for (int k = 0; k < N_IN; k++) v[k*DW +: DW] = DW'(e);
    return v;
  endfunction

  // All driver tasks start and end at a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; we = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NW; i++) wm[i] = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_w(input int a, input int v);
    we = 1'b1; w_addr = AW'(a); w_data = DW'(v);
    @(negedge clk);
    we = 1'b0;
    wm[a] = v;
  endtask

  task automatic fill(input int w, input int b);
    for (int j = 0; j < N_OUT; j++)
      for (int k = 0; k <= N_IN; k++) write_w(j*(N_IN+1)+k, (k == N_IN) ? b : w);
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < NW; i++) write_w(i, int'($urandom_range(0, hi - lo)) + lo);
  endtask

  task automatic run_pass(input string name, input logic [IW-1:0] iv, input logic mode,
                          output logic [OW-1:0] got);
    logic [OW-1:0] prev, exp;
    int            cyc;
    logic          held;
    exp_q.push_back(model(iv, mode));
    prev = out_val;
    in_val = iv; act_mode = mode; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; held = 1'b1;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_start got=%b want=1", name, busy); end
    while (done !== 1'b1 && cyc < 200) begin
      if (out_val !== prev) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc != LAT) begin n_err++; $display("FAIL %s latency got=%0d want=%0d", name, cyc, LAT); end
    n_vec++;
    if (held !== 1'b1) begin n_err++; $display("FAIL %s out_val_changed_early got=0 want=1", name); end
    exp = exp_q.pop_front();
    got = out_val;
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL %s out_val got=%h want=%h", name, got, exp); end
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_with_done got=%b want=1", name, busy); end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s done_busy_fall got=%b%b want=00", name, done, busy);
    end
  endtask

  task automatic test_reset();
    logic [OW-1:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (out_val !== '0 || done !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      n_err++; $display("FAIL reset_state got=%h/%b/%b want=0/0/0", out_val, done, busy);
    end
    do_reset();
    run_pass("reset_zero_weights", rand_vec(-512, 511), ACT_LINEAR, got);
    n_vec++;
    if (got !== '0) begin n_err++; $display("FAIL reset_zero_out got=%h want=0", got); end
  endtask

  task automatic test_identity();
    logic [OW-1:0] got;
    fill(16, 0);
    run_pass("identity", const_vec(16), ACT_RELU, got);
    n_vec++;
    if (got !== {N_OUT{10'd160}}) begin n_err++; $display("FAIL identity_const got=%h want=all 0a0", got); end
  endtask

  task automatic test_saturation();
    logic [OW-1:0] got;
    fill(48, 0);
    run_pass("sat_pos", const_vec(64), ACT_RELU, got);
    n_vec++;
    if (got !== {N_OUT{10'd511}}) begin n_err++; $display("FAIL sat_pos_const got=%h want=all 1ff", got); end
    fill(-48, 0);
    run_pass("sat_neg", const_vec(64), ACT_LINEAR, got);
    n_vec++;
    if (got !== {N_OUT{10'h200}}) begin n_err++; $display("FAIL sat_neg_const got=%h want=all 200", got); end
  endtask

  task automatic test_activation();
    logic [OW-1:0] got, want;
    fill(-16, 0);
    run_pass("relu_neg", const_vec(16), ACT_RELU, got);
    n_vec++;
    if (got !== '0) begin n_err++; $display("FAIL relu_neg_const got=%h want=0", got); end
    run_pass("linear_neg", const_vec(16), ACT_LINEAR, got);
    n_vec++;
    if (got !== {N_OUT{10'h360}}) begin n_err++; $display("FAIL linear_neg_const got=%h want=all 360", got); end
    fill(0, 0);
    write_w(2*(N_IN+1)+N_IN, 40);
    want = '0; want[2*DW +: DW] = 10'd40;
    run_pass("bias_only", rand_vec(-512, 511), ACT_RELU, got);
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL bias_only_const got=%h want=%h", got, want); end
  endtask

  task automatic test_random();
    logic [OW-1:0] got;
    for (int p = 0; p < 4; p++) begin
      if (p < 2) fill_rand(-40, 40); else fill_rand(-512, 511);
      run_pass("random", rand_vec(-512, 511), 1'($urandom_range(0, 1)), got);
    end
  endtask

  task automatic test_protocol();
    logic [IW-1:0] iv;
    logic [OW-1:0] exp, got;
    int            pulses;
    fill_rand(-40, 40);
    iv = rand_vec(-512, 511);
    exp = model(iv, ACT_LINEAR);
    got = '0; pulses = 0;
    in_val = iv; act_mode = ACT_LINEAR; start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < LAT + 10; c++) begin
      if (c == 10) begin
        start = 1'b1; we = 1'b1; w_addr = '0; w_data = ~DW'(wm[0]);
        in_val = rand_vec(-512, 511); act_mode = ACT_RELU;
      end else begin
        start = 1'b0; we = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin pulses++; got = out_val; end
    end
    n_vec++;
    if (pulses != 1) begin n_err++; $display("FAIL protocol_pulses got=%0d want=1", pulses); end
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL protocol_result got=%h want=%h", got, exp); end
    run_pass("protocol_weight_kept", iv, ACT_LINEAR, got);
  endtask

  task automatic test_same_cycle_write();
    logic [OW-1:0] got;
    fill(16, 0);
    we = 1'b1; w_addr = '0; w_data = DW'(-16);
    run_pass("same_cycle_old_weight", const_vec(16), ACT_RELU, got);
    we = 1'b0;
    wm[0] = -16;
    run_pass("same_cycle_new_weight", const_vec(16), ACT_RELU, got);
    n_vec++;
    if (got[DW-1:0] !== 10'd128) begin n_err++; $display("FAIL same_cycle_n0 got=%0d want=128", got[DW-1:0]); end
  endtask

  task automatic test_midpass_reset();
    logic [OW-1:0] got;
    int            pulses;
    fill_rand(-40, 40);
    in_val = rand_vec(-512, 511); act_mode = ACT_LINEAR; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || out_val !== '0 || dbg_state !== IDLE) begin
      n_err++; $display("FAIL midpass_reset got=%b/%b/%h want=0/0/0", busy, done, out_val);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NW; i++) wm[i] = 0;
    pulses = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin n_err++; $display("FAIL midpass_no_done got=%0d want=0", pulses); end
    fill_rand(-60, 60);
    run_pass("after_midpass_reset", rand_vec(-512, 511), ACT_LINEAR, got);
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] got;
    fill_rand(-40, 40);
    for (int p = 0; p < 3; p++) run_pass("back_to_back", rand_vec(-512, 511), 1'(p & 1), got);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_activation();
    test_random();
    test_protocol();
    test_same_cycle_write();
    test_midpass_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
